// File: rtl/accumulator_rmw.sv
// rtl/accumulator_rmw.sv - per-column accumulator memory with skewed writes, saturating RMW, registered read and bulk clear
module accumulator_rmw #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int ACC_WIDTH         = PARTIAL_SUM_WIDTH + 4,
  parameter int PATTERN_NUMBER    = 1,
  parameter int DEPTH             = PATTERN_NUMBER * SYSTOLIC_SIZE,
  parameter int ADDR_WIDTH        = $clog2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic                                   acc_mode,
  input  logic [ADDR_WIDTH-1:0]                  wr_addr,
  input  logic                                   test_mode,
  input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] partial_sum_inputs_flat,
  input  logic                                   rd_en,
  input  logic [ADDR_WIDTH-1:0]                  rd_addr,
  input  logic                                   clr_start,
  output logic [ACC_WIDTH*SYSTOLIC_SIZE-1:0]     rd_data_flat,
  output logic                                   rd_valid,
  output logic                                   busy,
  output logic                                   wr_drop,
  output logic [SYSTOLIC_SIZE-1:0]               ovf
);

  localparam int NSTG       = (SYSTOLIC_SIZE > 1) ? SYSTOLIC_SIZE - 1 : 1;
  localparam int DCW        = (SYSTOLIC_SIZE > 2) ? $clog2(SYSTOLIC_SIZE - 1) : 1;
  localparam int DRAIN_LAST = (SYSTOLIC_SIZE > 1) ? SYSTOLIC_SIZE - 2 : 0;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  state_t                state_q, state_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  clr_en;
  logic                  clr_done;

  logic [ACC_WIDTH-1:0]  mem_q [SYSTOLIC_SIZE][DEPTH];
  logic [ACC_WIDTH-1:0]  mem_d [SYSTOLIC_SIZE][DEPTH];

  logic [NSTG-1:0]       stg_we_q, stg_we_d;
  logic [NSTG-1:0]       stg_mode_q, stg_mode_d;
  logic [ADDR_WIDTH-1:0] stg_addr_q [NSTG];
  logic [ADDR_WIDTH-1:0] stg_addr_d [NSTG];

  logic [ACC_WIDTH*SYSTOLIC_SIZE-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_drop_q, wr_drop_d;
  logic [SYSTOLIC_SIZE-1:0] ovf_q, ovf_d;

  logic                  cmd_we;
  logic [SYSTOLIC_SIZE-1:0] col_we;
  logic [SYSTOLIC_SIZE-1:0] col_mode;
  logic [SYSTOLIC_SIZE-1:0] col_clip;
  logic [ADDR_WIDTH-1:0] col_addr [SYSTOLIC_SIZE];
  logic [ACC_WIDTH-1:0]  col_x    [SYSTOLIC_SIZE];
  logic [ACC_WIDTH-1:0]  col_sat  [SYSTOLIC_SIZE];

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // Clear FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      clr_ptr_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      clr_ptr_q   <= clr_ptr_d;
    end
  end

  // Clear FSM: next state
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    clr_ptr_d   = clr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          drain_cnt_d = '0;
          clr_ptr_d   = '0;
          state_d     = (SYSTOLIC_SIZE > 1) ? ST_DRAIN : ST_CLEAR;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DCW'(DRAIN_LAST)) state_d = ST_CLEAR;
        else drain_cnt_d = drain_cnt_q + 1'b1;
      end
      ST_CLEAR: begin
        if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    busy     = (state_q != ST_IDLE);
    clr_en   = (state_q == ST_CLEAR);
    clr_done = (state_q == ST_CLEAR) && (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1));
  end

  assign cmd_we = wr_en & ~busy;

  // Skew chain shifts every cycle; test_mode only affects which command the columns execute
  always_comb begin
    stg_we_d      = stg_we_q;
    stg_mode_d    = stg_mode_q;
    stg_addr_d    = stg_addr_q;
    stg_we_d[0]   = cmd_we;
    stg_mode_d[0] = acc_mode;
    stg_addr_d[0] = wr_addr;
    for (int k = 1; k < NSTG; k++) begin
      stg_we_d[k]   = stg_we_q[k-1];
      stg_mode_d[k] = stg_mode_q[k-1];
      stg_addr_d[k] = stg_addr_q[k-1];
    end
  end

  for (genvar c = 0; c < SYSTOLIC_SIZE; c++) begin : g_col
    logic [PARTIAL_SUM_WIDTH-1:0] ps;
    logic [ACC_WIDTH-1:0]         cur;
    logic [ACC_WIDTH:0]           sum;

    assign ps       = partial_sum_inputs_flat[c*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH];
    assign col_x[c] = {{(ACC_WIDTH-PARTIAL_SUM_WIDTH){ps[PARTIAL_SUM_WIDTH-1]}}, ps};

    if (c == 0) begin : g_direct
      assign col_we[c]   = cmd_we;
      assign col_mode[c] = acc_mode;
      assign col_addr[c] = wr_addr;
    end else begin : g_skew
      assign col_we[c]   = test_mode ? cmd_we   : stg_we_q[c-1];
      assign col_mode[c] = test_mode ? acc_mode : stg_mode_q[c-1];
      assign col_addr[c] = test_mode ? wr_addr  : stg_addr_q[c-1];
    end

    // One extra bit of headroom: overflow shows as disagreement of the top two sum bits
    assign cur         = mem_q[c][col_addr[c]];
    assign sum         = {cur[ACC_WIDTH-1], cur} + {col_x[c][ACC_WIDTH-1], col_x[c]};
    assign col_clip[c] = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign col_sat[c]  = col_clip[c] ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    mem_d = mem_q;
    ovf_d = ovf_q;
    for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
      if (col_we[c] && addr_ok(col_addr[c])) begin
        if (!col_mode[c]) begin
          mem_d[c][col_addr[c]] = col_x[c];
        end else begin
          mem_d[c][col_addr[c]] = col_sat[c];
          if (col_clip[c]) ovf_d[c] = 1'b1;
        end
      end
    end
    if (clr_en) begin
      for (int c = 0; c < SYSTOLIC_SIZE; c++) mem_d[c][clr_ptr_q] = '0;
    end
    if (clr_done) ovf_d = '0;
  end

  always_comb begin
    wr_drop_d = wr_drop_q | (wr_en & busy);
    if (clr_done) wr_drop_d = 1'b0;
  end

  // Reads sample pre-write memory, so a same-cycle write is not forwarded
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
        rd_data_d[c*ACC_WIDTH +: ACC_WIDTH] = addr_ok(rd_addr) ? mem_q[c][rd_addr] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
        for (int a = 0; a < DEPTH; a++) mem_q[c][a] <= '0;
      end
      stg_we_q   <= '0;
      stg_mode_q <= '0;
      for (int k = 0; k < NSTG; k++) stg_addr_q[k] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      ovf_q      <= '0;
    end else begin
      mem_q      <= mem_d;
      stg_we_q   <= stg_we_d;
      stg_mode_q <= stg_mode_d;
      stg_addr_q <= stg_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_drop_q  <= wr_drop_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_data_flat = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign wr_drop      = wr_drop_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_accumulator_rmw.sv
// tb/tb_accumulator_rmw.sv - randomized self-checking bench for accumulator_rmw against a behavioural model
module tb_accumulator_rmw;

  localparam int S     = 8;
  localparam int PSW   = 19;
  localparam int AW    = 23;
  localparam int DEPTH = 8;
  localparam longint MAXV = 4194303;
  localparam longint MINV = -4194304;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en, acc_mode, test_mode, rd_en, clr_start;
  logic [2:0]     wr_addr, rd_addr;
  logic [PSW*S-1:0] ps_flat;
  logic [AW*S-1:0]  rd_data_flat;
  logic           rd_valid, busy, wr_drop;
  logic [S-1:0]   ovf;

  int errors = 0;
  int checks = 0;

  longint mdl [S][DEPTH];
  logic [S-1:0] m_ovf;
  longint dv [S];

  accumulator_rmw dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .acc_mode(acc_mode), .wr_addr(wr_addr),
    .test_mode(test_mode), .partial_sum_inputs_flat(ps_flat), .rd_en(rd_en), .rd_addr(rd_addr),
    .clr_start(clr_start), .rd_data_flat(rd_data_flat), .rd_valid(rd_valid), .busy(busy),
    .wr_drop(wr_drop), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint rnd_ps(input int lim);
    return longint'($urandom_range(0, 2 * lim - 1)) - longint'(lim);
  endfunction

  function automatic logic [AW*S-1:0] exp_row(input int a);
    logic [AW*S-1:0] r;
    longint v;
    for (int c = 0; c < S; c++) begin
      v = mdl[c][a];
      r[c*AW +: AW] = v[AW-1:0];
    end
    return r;
  endfunction

  task automatic model_zero();
    for (int c = 0; c < S; c++) for (int a = 0; a < DEPTH; a++) mdl[c][a] = 0;
    m_ovf = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_col(input int c, input longint v);
    ps_flat[c*PSW +: PSW] = v[PSW-1:0];
  endtask

  task automatic bcast_write(input int a, input bit mode);
    longint s;
    test_mode = 1'b1;
    wr_en     = 1'b1;
    acc_mode  = mode;
    wr_addr   = 3'(a);
    for (int c = 0; c < S; c++) set_col(c, dv[c]);
    tick();
    wr_en = 1'b0;
    for (int c = 0; c < S; c++) begin
      if (!mode) mdl[c][a] = dv[c];
      else begin
        s = mdl[c][a] + dv[c];
        if (s > MAXV || s < MINV) m_ovf[c] = 1'b1;
        mdl[c][a] = sat(s);
      end
    end
  endtask

  task automatic do_read(input int a);
    rd_en   = 1'b1;
    rd_addr = 3'(a);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf got=%h exp=00", ovf); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a);
      checks++;
      if (rd_valid !== 1'b1 || rd_data_flat !== '0) begin
        errors++; $display("FAIL reset_read addr=%0d valid=%b got=%h exp=0", a, rd_valid, rd_data_flat);
      end
    end
  endtask

  task automatic test_skew();
    longint old [S];
    logic [AW*S-1:0] e;
    longint v;
    for (int c = 0; c < S; c++) dv[c] = rnd_ps(262144);
    bcast_write(3, 1'b0);
    repeat (S) tick();
    for (int c = 0; c < S; c++) old[c] = mdl[c][3];
    test_mode = 1'b0;
    for (int k = 0; k <= S; k++) begin
      wr_en    = (k == 0);
      acc_mode = 1'b0;
      wr_addr  = 3'd3;
      for (int c = 0; c < S; c++) set_col(c, (c == k) ? longint'(10 + c) : rnd_ps(262144));
      rd_en    = (k >= 1);
      rd_addr  = 3'd3;
      tick();
      if (k >= 1) begin
        for (int c = 0; c < S; c++) begin
          v = (c < k) ? longint'(10 + c) : old[c];
          e[c*AW +: AW] = v[AW-1:0];
        end
        checks++;
        if (rd_data_flat !== e) begin
          errors++; $display("FAIL skew_step%0d got=%h exp=%h", k, rd_data_flat, e);
        end
      end
    end
    rd_en = 1'b0;
    test_mode = 1'b1;
    for (int c = 0; c < S; c++) mdl[c][3] = 10 + c;
  endtask

  task automatic test_broadcast();
    int a;
    for (int c = 0; c < S; c++) dv[c] = 'h55;
    bcast_write(5, 1'b0);
    do_read(5);
    checks++;
    if (rd_valid !== 1'b1 || rd_data_flat !== exp_row(5)) begin
      errors++; $display("FAIL bcast_read valid=%b got=%h exp=%h", rd_valid, rd_data_flat, exp_row(5));
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data_flat !== exp_row(5)) begin
      errors++; $display("FAIL bcast_hold valid=%b got=%h exp=%h", rd_valid, rd_data_flat, exp_row(5));
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      for (int c = 0; c < S; c++) dv[c] = rnd_ps(262144);
      bcast_write(a, 1'b0);
      do_read(a);
      checks++;
      if (rd_data_flat !== exp_row(a)) begin
        errors++; $display("FAIL bcast_rand addr=%0d got=%h exp=%h", a, rd_data_flat, exp_row(a));
      end
    end
  endtask

  task automatic test_accumulate();
    int a;
    logic [AW*S-1:0] e77;
    longint v77;
    a = $urandom_range(0, DEPTH - 1);
    v77 = 77;
    for (int c = 0; c < S; c++) e77[c*AW +: AW] = v77[AW-1:0];
    for (int c = 0; c < S; c++) dv[c] = 100;
    bcast_write(a, 1'b0);
    for (int c = 0; c < S; c++) dv[c] = -30;
    bcast_write(a, 1'b1);
    for (int c = 0; c < S; c++) dv[c] = 7;
    bcast_write(a, 1'b1);
    do_read(a);
    checks++;
    if (rd_data_flat !== e77) begin errors++; $display("FAIL acc_77 got=%h exp=%h", rd_data_flat, e77); end
    for (int c = 0; c < S; c++) dv[c] = rnd_ps(1000);
    rd_en   = 1'b1;
    rd_addr = 3'(a);
    bcast_write(a, 1'b1);
    rd_en = 1'b0;
    checks++;
    if (rd_data_flat !== e77) begin errors++; $display("FAIL acc_same_cycle got=%h exp=%h", rd_data_flat, e77); end
    do_read(a);
    checks++;
    if (rd_data_flat !== exp_row(a)) begin
      errors++; $display("FAIL acc_after_rmw got=%h exp=%h", rd_data_flat, exp_row(a));
    end
    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < S; c++) dv[c] = rnd_ps(65536);
      bcast_write($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < DEPTH; r++) begin
      do_read(r);
      checks++;
      if (rd_data_flat !== exp_row(r)) begin
        errors++; $display("FAIL acc_rand addr=%0d got=%h exp=%h", r, rd_data_flat, exp_row(r));
      end
    end
    checks++;
    if (ovf !== m_ovf) begin errors++; $display("FAIL acc_ovf got=%h exp=%h", ovf, m_ovf); end
  endtask

  task automatic test_saturation();
    int a, sc, nc;
    a  = $urandom_range(0, DEPTH - 1);
    sc = $urandom_range(0, S - 1);
    nc = (sc + 1 + $urandom_range(0, S - 2)) % S;
    for (int c = 0; c < S; c++) dv[c] = 0;
    dv[sc] = 262143;
    dv[nc] = -262144;
    bcast_write(a, 1'b0);
    repeat (15) bcast_write(a, 1'b1);
    dv[sc] = 14;
    dv[nc] = 0;
    bcast_write(a, 1'b1);
    do_read(a);
    checks++;
    if (rd_data_flat[sc*AW +: AW] !== 23'd4194302) begin
      errors++; $display("FAIL sat_near_max got=%h exp=%h", rd_data_flat[sc*AW +: AW], 23'd4194302);
    end
    checks++;
    if (rd_data_flat[nc*AW +: AW] !== 23'h400000 || ovf[nc] !== 1'b0) begin
      errors++; $display("FAIL sat_at_min got=%h ovf=%b exp=400000 ovf=0", rd_data_flat[nc*AW +: AW], ovf[nc]);
    end
    dv[sc] = 5;
    bcast_write(a, 1'b1);
    do_read(a);
    checks++;
    if (rd_data_flat[sc*AW +: AW] !== 23'h3fffff || ovf[sc] !== 1'b1 || ovf[nc] !== 1'b0) begin
      errors++; $display("FAIL sat_pos got=%h ovf=%h exp=3fffff", rd_data_flat[sc*AW +: AW], ovf);
    end
    checks++;
    if (ovf !== m_ovf) begin errors++; $display("FAIL sat_pos_ovf got=%h exp=%h", ovf, m_ovf); end
    dv[sc] = 0;
    dv[nc] = -262144;
    bcast_write(a, 1'b1);
    do_read(a);
    checks++;
    if (rd_data_flat[nc*AW +: AW] !== 23'h400000 || ovf[nc] !== 1'b1) begin
      errors++; $display("FAIL sat_neg got=%h ovf=%b exp=400000 ovf=1", rd_data_flat[nc*AW +: AW], ovf[nc]);
    end
    checks++;
    if (rd_data_flat !== exp_row(a) || ovf !== m_ovf) begin
      errors++; $display("FAIL sat_row got=%h ovf=%h exp=%h ovf=%h", rd_data_flat, ovf, exp_row(a), m_ovf);
    end
  endtask

  task automatic test_clear();
    int a, busy_cycles;
    bit done;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < S; c++) dv[c] = rnd_ps(262144);
      bcast_write(r, 1'b0);
    end
    a = $urandom_range(0, DEPTH - 1);
    for (int c = 0; c < S; c++) dv[c] = rnd_ps(262144);
    clr_start = 1'b1;
    bcast_write(a, 1'b0);
    clr_start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise got=%b exp=1", busy); end
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      wr_en   = (i < 3);
      rd_en   = (i == 0);
      rd_addr = 3'(a);
      for (int c = 0; c < S; c++) set_col(c, rnd_ps(262144));
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (i == 0) begin
        checks++;
        if (rd_data_flat !== exp_row(a) || wr_drop !== 1'b1) begin
          errors++; $display("FAIL clr_busy_read got=%h drop=%b exp=%h drop=1", rd_data_flat, wr_drop, exp_row(a));
        end
      end
      if (busy) busy_cycles++;
      else done = 1'b1;
    end
    checks++;
    if (!done || busy_cycles != S - 1 + DEPTH) begin
      errors++; $display("FAIL clr_busy_len got=%0d exp=%0d", busy_cycles, S - 1 + DEPTH);
    end
    model_zero();
    checks++;
    if (wr_drop !== 1'b0 || ovf !== 8'h00) begin
      errors++; $display("FAIL clr_flags drop=%b ovf=%h exp=0/00", wr_drop, ovf);
    end
    for (int r = 0; r < DEPTH; r++) begin
      do_read(r);
      checks++;
      if (rd_data_flat !== '0) begin errors++; $display("FAIL clr_read addr=%0d got=%h exp=0", r, rd_data_flat); end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int c = 0; c < S; c++) dv[c] = 1 + $urandom_range(0, 1000);
    bcast_write(2, 1'b0);
    do_read(2);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || wr_drop !== 1'b0 || ovf !== 8'h00 || rd_data_flat !== '0) begin
      errors++; $display("FAIL rst_mid_clear busy=%b valid=%b drop=%b ovf=%h data=%h exp all 0",
                         busy, rd_valid, wr_drop, ovf, rd_data_flat);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_zero();
    for (int r = 0; r < DEPTH; r++) begin
      do_read(r);
      checks++;
      if (rd_data_flat !== '0) begin errors++; $display("FAIL rst_read addr=%0d got=%h exp=0", r, rd_data_flat); end
    end
    for (int c = 0; c < S; c++) dv[c] = rnd_ps(262144);
    bcast_write(6, 1'b0);
    do_read(6);
    checks++;
    if (busy !== 1'b0 || rd_data_flat !== exp_row(6)) begin
      errors++; $display("FAIL rst_idle_write busy=%b got=%h exp=%h", busy, rd_data_flat, exp_row(6));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; acc_mode = 1'b0; test_mode = 1'b1; rd_en = 1'b0; clr_start = 1'b0;
    wr_addr = '0; rd_addr = '0; ps_flat = '0;
    model_zero();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_skew();
    test_broadcast();
    test_accumulate();
    test_saturation();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
